xrom_reader: RTL

- Sequencer directly upstream and downstream of the synchronous ROM.
- Issues a burst of ROM read addresses (base, length, optional loop) and captures the 1-cycle-latency ROM data.
- Re-times that data into a 4-entry buffer and presents it as a valid/ready stream with an end-of-burst marker.
- Absorbs downstream backpressure, which the ROM itself cannot, while sustaining 1 word/cycle when unstalled.

---
 rtl/xrom_reader_pkg.sv | 21 ++
 rtl/xrom_reader_if.sv | 33 +++
 rtl/xfifo_sync.sv | 79 +++++++
 rtl/xrom_reader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/xrom_reader_pkg.sv
// ---------------------------------------------------------------------------
// xrom_reader_pkg
// Shared definitions for the ROM burst reader slice.
//   state_t        : sequencer states (IDLE / RUN / DRAIN)
//   BUF_DEPTH      : entries in the output re-timing buffer
//   INFLIGHT_DEPTH : ROM reads that can be outstanding at once
//   CNT_W          : width of a counter able to hold 0..BUF_DEPTH
// ---------------------------------------------------------------------------
package xrom_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int BUF_DEPTH      = 4;
   localparam int INFLIGHT_DEPTH = 2;
   localparam int CNT_W          = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/xrom_reader_if.sv
// ---------------------------------------------------------------------------
// xrom_reader_if
// Valid/ready output stream of the ROM reader.
//   m_valid : word available at the buffer head
//   m_data  : word payload (ROM data)
//   m_last  : final word of a burst pass
//   m_ready : downstream accepts the word this cycle
// master modport = reader side, slave modport = consumer side.
// ---------------------------------------------------------------------------
interface xrom_reader_if #(
   parameter int BWID = 32
);

   logic            m_valid;
   logic [BWID-1:0] m_data;
   logic            m_last;
   logic            m_ready;

   modport master (
      output m_valid,
      output m_data,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      input  m_last,
      output m_ready
   );

endinterface

// File: rtl/xfifo_sync.sv
// ---------------------------------------------------------------------------
// xfifo_sync
// Small synchronous FIFO (BUF_DEPTH entries) used to re-time ROM data into a
// stream that can be stalled.
//   clk, rst     : clock, synchronous active-high reset
//   i_flush      : empties the FIFO at the next edge (wins over push/pop)
//   i_push       : write i_pushData at the tail
//   i_pushData   : entry to store
//   i_pop        : discard the head entry
//   o_headData   : current head entry
//   o_empty      : no entries stored
//   o_count      : number of stored entries
// ---------------------------------------------------------------------------
module xfifo_sync
   import xrom_reader_pkg::*;
#(
   parameter int WIDTH = 33
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_flush,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_pushData,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_headData,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   localparam int PTR_W = $clog2(BUF_DEPTH);

   logic [WIDTH-1:0] r_mem [BUF_DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;
   logic             w_doPop;
   logic             w_doPush;

   // A pop needs something to pop; a push is taken when there is space, or
   // when the same edge frees a slot through a pop.
   assign w_doPop  = i_pop && (r_count != '0);
   assign w_doPush = i_push && ((r_count != CNT_W'(BUF_DEPTH)) || w_doPop);

   // Storage and pointer update. Storage is cleared on reset so the head
   // word reads as zero straight after reset; a flush only resets pointers
   // since stale contents are never exposed while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
            r_wrPtr        <= r_wrPtr + PTR_W'(1);
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_headData = r_mem[r_rdPtr];
   assign o_empty    = (r_count == '0);
   assign o_count    = r_count;

endmodule

// File: rtl/xrom_reader.sv
// ---------------------------------------------------------------------------
// xrom_reader
// Burst sequencer sitting in front of and behind a 1-cycle-latency ROM. It
// issues base..base+len-1 (optionally looping), captures the returning data
// and re-times it through a 4-entry FIFO onto a valid/ready stream.
//   clk, rst      : clock, synchronous active-high reset
//   i_start       : burst request, only honoured in IDLE
//   i_base_addr   : first ROM address of the burst
//   i_len         : burst length in words (0..2**BWID_ADDR)
//   i_loop        : repeat the burst until abort
//   i_abort       : stop and flush from any state
//   o_busy        : burst in progress
//   o_done        : one-cycle pulse when a non-looping burst has drained
//   o_rom_addr    : ROM address (registered)
//   o_rom_nd      : ROM read strobe (registered)
//   i_rom_dout    : ROM read data
//   strm          : output stream (master side)
// ---------------------------------------------------------------------------
module xrom_reader
   import xrom_reader_pkg::*;
#(
   parameter int BWID      = 32,
   parameter int BWID_ADDR = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   input  logic [BWID_ADDR-1:0] i_base_addr,
   input  logic [BWID_ADDR:0]   i_len,
   input  logic                 i_loop,
   input  logic                 i_abort,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [BWID_ADDR-1:0] o_rom_addr,
   output logic                 o_rom_nd,
   input  logic [BWID-1:0]      i_rom_dout,
   xrom_reader_if.master        strm
);

   localparam logic [CNT_W:0] ROOM_LIMIT = (CNT_W + 1)'(BUF_DEPTH);

   state_t                      r_state;
   state_t                      w_nextState;

   logic [BWID_ADDR-1:0]        r_base;
   logic [BWID_ADDR:0]          r_len;
   logic                        r_loop;
   logic [BWID_ADDR:0]          r_idx;
   logic [BWID_ADDR-1:0]        r_romAddr;
   logic [INFLIGHT_DEPTH-1:0]   r_ndPipe;
   logic [INFLIGHT_DEPTH-1:0]   r_lastPipe;
   logic                        r_zeroDone;

   logic                        w_accept;
   logic                        w_acceptRun;
   logic                        w_issue;
   logic [BWID_ADDR-1:0]        w_issueAddr;
   logic                        w_issueLast;
   logic [BWID_ADDR:0]          w_nextIdx;
   logic [CNT_W-1:0]            w_inflight;
   logic [CNT_W-1:0]            w_count;
   logic                        w_room;
   logic                        w_drained;
   logic                        w_empty;
   logic                        w_pop;
   logic [BWID:0]               w_head;

   // A start is only accepted from IDLE, and abort beats a coincident start.
   assign w_accept    = (r_state == ST_IDLE) && i_start && !i_abort;
   assign w_acceptRun = w_accept && (i_len != '0);

   // Count the reads still travelling through the ROM. Slot 0 is the read
   // strobe currently at the ROM, the last slot is the word landing now.
   always_comb begin
      w_inflight = '0;
      for (int i = 0; i < INFLIGHT_DEPTH; i++) begin
         w_inflight = w_inflight + {{(CNT_W - 1){1'b0}}, r_ndPipe[i]};
      end
   end

   // Issue only if buffered plus outstanding words leave a free slot; this
   // ignores same-cycle pops so the buffer can never overflow.
   assign w_room    = ({1'b0, w_count} + {1'b0, w_inflight}) < ROOM_LIMIT;
   assign w_drained = (w_count == '0) && (r_ndPipe == '0);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and issue decision. Because the ROM strobe is registered,
   // the read decided in the start cycle appears on the ROM in the first
   // busy cycle, which keeps start-to-data latency at three cycles. The final
   // index sets the last flag; a looping burst wraps idx to 0 with no gap.
   always_comb begin
      w_nextState = r_state;
      w_issue     = 1'b0;
      w_issueAddr = r_romAddr;
      w_issueLast = 1'b0;
      w_nextIdx   = r_idx;
      case (r_state)
         ST_IDLE: begin
            if (w_acceptRun) begin
               w_issue     = 1'b1;
               w_issueAddr = i_base_addr;
               if (i_len == (BWID_ADDR + 1)'(1)) begin
                  w_issueLast = 1'b1;
                  w_nextIdx   = '0;
                  w_nextState = i_loop ? ST_RUN : ST_DRAIN;
               end else begin
                  w_nextIdx   = (BWID_ADDR + 1)'(1);
                  w_nextState = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (w_room) begin
               w_issue     = 1'b1;
               w_issueAddr = r_base + r_idx[BWID_ADDR-1:0];
               if (r_idx == (r_len - (BWID_ADDR + 1)'(1))) begin
                  w_issueLast = 1'b1;
                  w_nextIdx   = '0;
                  if (!r_loop) begin
                     w_nextState = ST_DRAIN;
                  end
               end else begin
                  w_nextIdx = r_idx + (BWID_ADDR + 1)'(1);
               end
            end
         end
         ST_DRAIN: begin
            if (w_drained) begin
               w_nextState = ST_IDLE;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
      if (i_abort) begin
         w_nextState = ST_IDLE;
         w_issue     = 1'b0;
      end
   end

   // Status outputs. done fires in the DRAIN->IDLE cycle, or one cycle after
   // a zero-length start; an abort suppresses it.
   always_comb begin
      o_busy = (r_state != ST_IDLE);
      o_done = r_zeroDone ||
               ((r_state == ST_DRAIN) && w_drained && !i_abort);
   end

   // Burst parameters, index counter, ROM strobe/address and the in-flight
   // shift register of read and last flags. Abort drops outstanding reads
   // but leaves the ROM address where it was.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_base     <= '0;
         r_len      <= '0;
         r_loop     <= 1'b0;
         r_idx      <= '0;
         r_romAddr  <= '0;
         r_ndPipe   <= '0;
         r_lastPipe <= '0;
         r_zeroDone <= 1'b0;
      end else if (i_abort) begin
         r_idx      <= '0;
         r_ndPipe   <= '0;
         r_lastPipe <= '0;
         r_zeroDone <= 1'b0;
      end else begin
         if (w_acceptRun) begin
            r_base <= i_base_addr;
            r_len  <= i_len;
            r_loop <= i_loop;
         end
         if (w_issue) begin
            r_romAddr <= w_issueAddr;
         end
         r_idx      <= w_nextIdx;
         r_ndPipe   <= {r_ndPipe[INFLIGHT_DEPTH-2:0], w_issue};
         r_lastPipe <= {r_lastPipe[INFLIGHT_DEPTH-2:0], w_issueLast};
         r_zeroDone <= w_accept && (i_len == '0);
      end
   end

   assign o_rom_addr = r_romAddr;
   assign o_rom_nd   = r_ndPipe[0];

   // The word landing this cycle is valid ROM output for the oldest read.
   assign w_pop = !w_empty && strm.m_ready;

   xfifo_sync #(
      .WIDTH (BWID + 1)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_flush    (i_abort),
      .i_push     (r_ndPipe[INFLIGHT_DEPTH-1]),
      .i_pushData ({r_lastPipe[INFLIGHT_DEPTH-1], i_rom_dout}),
      .i_pop      (w_pop),
      .o_headData (w_head),
      .o_empty    (w_empty),
      .o_count    (w_count)
   );

   assign strm.m_valid = !w_empty;
   assign strm.m_data  = w_head[BWID-1:0];
   assign strm.m_last  = w_head[BWID];

endmodule
